// File: rtl/p4_router_egress_buffer.sv
// Egress store-and-forward buffer: demuxes the wide packet bus into per-port partitions of one
// shared memory and drains committed packets to per-port AXIS outputs through a round-robin reader.
module p4_router_egress_buffer #(
  parameter int NUM_EGR_PHYS_PORTS    = 4,
  parameter int DATA_BYTES            = 64,
  parameter int EGR_BUF_DEPTH_PER_IFC = 512,
  parameter int MAX_PKTS_PER_IFC      = 32,
  parameter int PORT_ID_WIDTH         = 8
) (
  input  logic                                       clk,
  input  logic                                       sreset,
  input  logic                                       egr_tvalid,
  output logic                                       egr_tready,
  input  logic [DATA_BYTES*8-1:0]                    egr_tdata,
  input  logic [DATA_BYTES-1:0]                      egr_tkeep,
  input  logic                                       egr_tlast,
  input  logic [PORT_ID_WIDTH-1:0]                   egr_tdest,
  output logic [NUM_EGR_PHYS_PORTS-1:0]              port_tvalid,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]              port_tready,
  output logic [NUM_EGR_PHYS_PORTS*DATA_BYTES*8-1:0] port_tdata,
  output logic [NUM_EGR_PHYS_PORTS*DATA_BYTES-1:0]   port_tkeep,
  output logic [NUM_EGR_PHYS_PORTS-1:0]              port_tlast,
  output logic [NUM_EGR_PHYS_PORTS-1:0]              egr_buf_overflow,
  output logic                                       egr_bad_dest
);

  localparam int unsigned N     = NUM_EGR_PHYS_PORTS;
  localparam int unsigned KB    = DATA_BYTES;
  localparam int unsigned W     = DATA_BYTES * 8;
  localparam int unsigned DEPTH = EGR_BUF_DEPTH_PER_IFC;
  localparam int unsigned MAXP  = MAX_PKTS_PER_IFC;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned DIW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int unsigned CW    = $clog2(MAXP + 1);
  localparam int unsigned PW    = (N > 1) ? $clog2(N) : 1;

  // Write-side state
  logic                     rdy_q;
  logic                     sop_q;
  logic                     drop_q;
  logic [PORT_ID_WIDTH-1:0] cur_dest_q;
  logic [AW-1:0]            wr_ptr  [N];
  logic [AW-1:0]            cmt_ptr [N];
  logic [AW-1:0]            rd_ptr  [N];

  // Descriptor FIFOs
  logic [DIW-1:0]           d_wp   [N];
  logic [DIW-1:0]           d_rp   [N];
  logic [CW-1:0]            d_cnt  [N];
  logic [AW-1:0]            d_last [N][MAXP];
  logic [KB-1:0]            d_keep [N][MAXP];

  logic [W-1:0]             mem [N][DEPTH];

  // Read pipeline: s1 = registered read request, s2 = registered memory data
  logic [PW-1:0]            rr_q;
  logic                     s1_v, s1_last;
  logic [PW-1:0]            s1_p;
  logic [AW-1:0]            s1_a;
  logic [KB-1:0]            s1_keep;
  logic                     s2_v, s2_last;
  logic [PW-1:0]            s2_p;
  logic [KB-1:0]            s2_keep;
  logic [W-1:0]             s2_data;

  // Per-port 2-entry output FIFOs
  logic [W-1:0]             f_data [N][2];
  logic [KB-1:0]            f_keep [N][2];
  logic                     f_last [N][2];
  logic [N-1:0]             f_wp, f_rp;
  logic [1:0]               f_cnt [N];

  logic [N-1:0]             ovf_q;
  logic                     bad_q;

  // Write-path decode
  logic                     acc, bad, dropping, full, dfull;
  logic                     do_drop, do_write, do_push;
  logic [PORT_ID_WIDTH-1:0] dest;
  logic [PW-1:0]            wport;

  always_comb begin
    acc      = egr_tvalid && rdy_q;
    dest     = sop_q ? egr_tdest : cur_dest_q;
    bad      = 32'(dest) >= 32'(N);
    wport    = dest[PW-1:0];
    dropping = !sop_q && drop_q;
    full     = 1'b0;
    dfull    = 1'b0;
    if (!bad) begin
      full  = (wr_ptr[wport] + AW'(1)) == rd_ptr[wport];
      dfull = d_cnt[wport] == CW'(MAXP);
    end
    do_drop  = acc && !bad && (dropping || full || (sop_q && dfull));
    do_write = acc && !bad && !do_drop;
    do_push  = do_write && egr_tlast;
  end

  // Read scheduling
  logic [N-1:0]  elig;
  logic [N-1:0]  push_f, pop_f;
  logic [1:0]    infl;
  logic          sel_v, sel_last;
  logic [PW-1:0] sel_p;
  logic [KB-1:0] sel_keep;
  int unsigned   idx;

  always_comb begin
    elig = '0;
    infl = '0;
    for (int unsigned p = 0; p < N; p++) begin
      infl    = {1'b0, (s1_v && s1_p == PW'(p))} + {1'b0, (s2_v && s2_p == PW'(p))};
      elig[p] = (d_cnt[p] != '0) && (({1'b0, f_cnt[p]} + {1'b0, infl}) < 3'd2);
    end
    sel_v = 1'b0;
    sel_p = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(rr_q) + i) % N;
      if (!sel_v && elig[idx]) begin
        sel_v = 1'b1;
        sel_p = PW'(idx);
      end
    end
    sel_last = rd_ptr[sel_p] == d_last[sel_p][d_rp[sel_p]];
    sel_keep = sel_last ? d_keep[sel_p][d_rp[sel_p]] : '1;
    for (int unsigned p = 0; p < N; p++) begin
      push_f[p] = s2_v && s2_p == PW'(p);
      pop_f[p]  = (f_cnt[p] != 2'd0) && port_tready[p];
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      rdy_q      <= 1'b0;
      sop_q      <= 1'b1;
      drop_q     <= 1'b0;
      cur_dest_q <= '0;
      rr_q       <= '0;
      s1_v       <= 1'b0;
      s1_last    <= 1'b0;
      s1_p       <= '0;
      s1_a       <= '0;
      s1_keep    <= '0;
      s2_v       <= 1'b0;
      s2_last    <= 1'b0;
      s2_p       <= '0;
      s2_keep    <= '0;
      f_wp       <= '0;
      f_rp       <= '0;
      ovf_q      <= '0;
      bad_q      <= 1'b0;
      for (int unsigned p = 0; p < N; p++) begin
        wr_ptr[p]  <= '0;
        cmt_ptr[p] <= '0;
        rd_ptr[p]  <= '0;
        d_wp[p]    <= '0;
        d_rp[p]    <= '0;
        d_cnt[p]   <= '0;
        f_cnt[p]   <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      ovf_q <= '0;
      bad_q <= 1'b0;

      if (acc) begin
        sop_q <= egr_tlast;
        if (sop_q) cur_dest_q <= egr_tdest;
        if (bad && egr_tlast) bad_q <= 1'b1;
        // A drop rewinds to the last commit point so the partial packet leaves no trace
        if (do_drop) begin
          drop_q         <= !egr_tlast;
          wr_ptr[wport]  <= cmt_ptr[wport];
          if (egr_tlast) ovf_q[wport] <= 1'b1;
        end else begin
          drop_q <= 1'b0;
        end
        if (do_write) begin
          wr_ptr[wport] <= wr_ptr[wport] + AW'(1);
          if (egr_tlast) begin
            cmt_ptr[wport] <= wr_ptr[wport] + AW'(1);
            d_wp[wport]    <= (d_wp[wport] == DIW'(MAXP - 1)) ? '0 : d_wp[wport] + DIW'(1);
          end
        end
      end

      s1_v    <= sel_v;
      s1_p    <= sel_p;
      s1_a    <= rd_ptr[sel_p];
      s1_last <= sel_last;
      s1_keep <= sel_keep;
      if (sel_v) begin
        rr_q          <= (sel_p == PW'(N - 1)) ? '0 : sel_p + PW'(1);
        rd_ptr[sel_p] <= rd_ptr[sel_p] + AW'(1);
        if (sel_last)
          d_rp[sel_p] <= (d_rp[sel_p] == DIW'(MAXP - 1)) ? '0 : d_rp[sel_p] + DIW'(1);
      end

      s2_v    <= s1_v;
      s2_p    <= s1_p;
      s2_last <= s1_last;
      s2_keep <= s1_keep;

      for (int unsigned p = 0; p < N; p++) begin
        d_cnt[p] <= d_cnt[p] + CW'(do_push && wport == PW'(p))
                             - CW'(sel_v && sel_last && sel_p == PW'(p));
        f_cnt[p] <= f_cnt[p] + 2'(push_f[p]) - 2'(pop_f[p]);
        if (push_f[p]) f_wp[p] <= ~f_wp[p];
        if (pop_f[p])  f_rp[p] <= ~f_rp[p];
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked entirely by the pointers above
  always_ff @(posedge clk) begin
    if (do_write) mem[wport][wr_ptr[wport]] <= egr_tdata;
    if (do_push) begin
      d_last[wport][d_wp[wport]] <= wr_ptr[wport];
      d_keep[wport][d_wp[wport]] <= egr_tkeep;
    end
    s2_data <= mem[s1_p][s1_a];
    for (int unsigned p = 0; p < N; p++) begin
      if (push_f[p]) begin
        f_data[p][f_wp[p]] <= s2_data;
        f_keep[p][f_wp[p]] <= s2_keep;
        f_last[p][f_wp[p]] <= s2_last;
      end
    end
  end

  always_comb begin
    port_tvalid = '0;
    port_tdata  = '0;
    port_tkeep  = '0;
    port_tlast  = '0;
    for (int unsigned p = 0; p < N; p++) begin
      if (f_cnt[p] != 2'd0) begin
        port_tvalid[p]          = 1'b1;
        port_tdata[p*W +: W]    = f_data[p][f_rp[p]];
        port_tkeep[p*KB +: KB]  = f_keep[p][f_rp[p]];
        port_tlast[p]           = f_last[p][f_rp[p]];
      end
    end
  end

  assign egr_tready       = rdy_q;
  assign egr_buf_overflow = ovf_q;
  assign egr_bad_dest     = bad_q;

endmodule

// File: tb/tb_p4_router_egress_buffer.sv
// Directed bench for p4_router_egress_buffer: small partitions so overflow cases are short.
module tb_p4_router_egress_buffer;

  localparam int NP = 4;
  localparam int DB = 8;
  localparam int W  = DB * 8;

  logic              clk = 1'b0;
  logic              sreset;
  logic              egr_tvalid;
  logic              egr_tready;
  logic [W-1:0]      egr_tdata;
  logic [DB-1:0]     egr_tkeep;
  logic              egr_tlast;
  logic [7:0]        egr_tdest;
  logic [NP-1:0]     port_tvalid;
  logic [NP-1:0]     port_tready;
  logic [NP*W-1:0]   port_tdata;
  logic [NP*DB-1:0]  port_tkeep;
  logic [NP-1:0]     port_tlast;
  logic [NP-1:0]     egr_buf_overflow;
  logic              egr_bad_dest;

  p4_router_egress_buffer #(
    .NUM_EGR_PHYS_PORTS    (NP),
    .DATA_BYTES            (DB),
    .EGR_BUF_DEPTH_PER_IFC (16),
    .MAX_PKTS_PER_IFC      (4),
    .PORT_ID_WIDTH         (8)
  ) dut (
    .clk              (clk),
    .sreset           (sreset),
    .egr_tvalid       (egr_tvalid),
    .egr_tready       (egr_tready),
    .egr_tdata        (egr_tdata),
    .egr_tkeep        (egr_tkeep),
    .egr_tlast        (egr_tlast),
    .egr_tdest        (egr_tdest),
    .port_tvalid      (port_tvalid),
    .port_tready      (port_tready),
    .port_tdata       (port_tdata),
    .port_tkeep       (port_tkeep),
    .port_tlast       (port_tlast),
    .egr_buf_overflow (egr_buf_overflow),
    .egr_bad_dest     (egr_bad_dest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed output beats and pulse counts, sampled mid-cycle
  logic [W-1:0]  od [NP][64];
  logic [DB-1:0] ok [NP][64];
  logic          ol [NP][64];
  int            on [NP] = '{default: 0};
  int            ovf_cnt [NP] = '{default: 0};
  int            bad_cnt = 0;
  int            first_v1 = -1;

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (port_tvalid[p] && port_tready[p] && on[p] < 64) begin
        od[p][on[p]] = port_tdata[p*W +: W];
        ok[p][on[p]] = port_tkeep[p*DB +: DB];
        ol[p][on[p]] = port_tlast[p];
        on[p]++;
      end
      if (egr_buf_overflow[p]) ovf_cnt[p]++;
    end
    if (egr_bad_dest) bad_cnt++;
    if (port_tvalid[1] && first_v1 < 0) first_v1 = cyc;
  end

  int nchk  = 0;
  int nfail = 0;
  int last_t = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] dest, input int n, input logic [W-1:0] base,
                          input logic [DB-1:0] lkeep);
    for (int i = 0; i < n; i++) begin
      egr_tvalid = 1'b1;
      egr_tdata  = base + W'(i);
      egr_tlast  = (i == n - 1);
      egr_tkeep  = (i == n - 1) ? lkeep : '1;
      egr_tdest  = (i == 0) ? dest : 8'hEE;
      @(posedge clk);
      #1;
    end
    last_t     = cyc;
    egr_tvalid = 1'b0;
    egr_tlast  = 1'b0;
  endtask

  task automatic chk_pkt(input int p, input int s, input int n, input logic [W-1:0] base,
                         input logic [DB-1:0] lkeep);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("p%0d_b%0d_data", p, s + i), od[p][s+i], base + W'(i));
      chk($sformatf("p%0d_b%0d_keep", p, s + i), 64'(ok[p][s+i]), (i == n - 1) ? 64'(lkeep) : 64'hFF);
      chk($sformatf("p%0d_b%0d_last", p, s + i), 64'(ol[p][s+i]), (i == n - 1) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    sreset      = 1'b1;
    egr_tvalid  = 1'b0;
    egr_tdata   = '0;
    egr_tkeep   = '0;
    egr_tlast   = 1'b0;
    egr_tdest   = '0;
    port_tready = '1;
    idle(3);
    chk("rst_tready", 64'(egr_tready), 64'd0);
    chk("rst_tvalid", 64'(port_tvalid), 64'd0);
    chk("rst_tdata", port_tdata[63:0] | port_tdata[255:192], 64'd0);
    chk("rst_tkeep", 64'(port_tkeep), 64'd0);
    chk("rst_tlast", 64'(port_tlast), 64'd0);
    chk("rst_ovf", 64'(egr_buf_overflow), 64'd0);
    chk("rst_bad", 64'(egr_bad_dest), 64'd0);
    sreset = 1'b0;
    idle(1);
    chk("post_rst_tready", 64'(egr_tready), 64'd1);

    // 1: three-beat packet to port 1, latency from tlast
    send_pkt(8'd1, 3, 64'h1000, 8'h0F);
    idle(12);
    chk("t1_count", 64'(on[1]), 64'd3);
    chk_pkt(1, 0, 3, 64'h1000, 8'h0F);
    chk("t1_latency", 64'(first_v1 - last_t), 64'd3);

    // 2: oversized packet to port 0 is dropped, the next one survives
    send_pkt(8'd0, 20, 64'h2000, 8'hFF);
    idle(10);
    chk("t2_no_output", 64'(on[0]), 64'd0);
    chk("t2_ovf", 64'(ovf_cnt[0]), 64'd1);
    send_pkt(8'd0, 4, 64'h2100, 8'h03);
    idle(12);
    chk("t2_count", 64'(on[0]), 64'd4);
    chk_pkt(0, 0, 4, 64'h2100, 8'h03);

    // 3: bad destination
    send_pkt(8'd5, 2, 64'h3000, 8'hFF);
    idle(8);
    chk("t3_bad", 64'(bad_cnt), 64'd1);
    chk("t3_no_port", 64'(on[0] + on[1] + on[2] + on[3]), 64'd7);
    send_pkt(8'd2, 1, 64'h3100, 8'h01);
    idle(10);
    chk("t3_count", 64'(on[2]), 64'd1);
    chk_pkt(2, 0, 1, 64'h3100, 8'h01);
    chk("t3_bad_once", 64'(bad_cnt), 64'd1);

    // 4: stalled port 2 does not block port 3
    port_tready[2] = 1'b0;
    send_pkt(8'd2, 3, 64'h4000, 8'h7F);
    send_pkt(8'd3, 3, 64'h4100, 8'h3F);
    idle(15);
    chk("t4_p3_count", 64'(on[3]), 64'd3);
    chk_pkt(3, 0, 3, 64'h4100, 8'h3F);
    chk("t4_p2_held", 64'(on[2]), 64'd1);
    chk("t4_p2_valid", 64'(port_tvalid[2]), 64'd1);
    chk("t4_p2_data", port_tdata[2*W +: W], 64'h4000);
    idle(10);
    chk("t4_p2_valid2", 64'(port_tvalid[2]), 64'd1);
    chk("t4_p2_data2", port_tdata[2*W +: W], 64'h4000);
    port_tready[2] = 1'b1;
    idle(12);
    chk("t4_p2_count", 64'(on[2]), 64'd4);
    chk_pkt(2, 1, 3, 64'h4000, 8'h7F);

    // 5: descriptor exhaustion; two packets park in the output FIFO, four fill descriptors
    port_tready[0] = 1'b0;
    send_pkt(8'd0, 1, 64'h5000, 8'h01);
    send_pkt(8'd0, 1, 64'h5001, 8'h01);
    idle(8);
    for (int k = 0; k < 5; k++) send_pkt(8'd0, 1, 64'h5002 + W'(k), 8'h01);
    idle(4);
    chk("t5_ovf", 64'(ovf_cnt[0]), 64'd2);
    chk("t5_stalled", 64'(on[0]), 64'd4);
    port_tready[0] = 1'b1;
    idle(24);
    chk("t5_count", 64'(on[0]), 64'd10);
    for (int i = 0; i < 6; i++) chk_pkt(0, 4 + i, 1, 64'h5000 + W'(i), 8'h01);

    // 6: reset in the middle of a packet
    egr_tvalid = 1'b1;
    egr_tlast  = 1'b0;
    egr_tkeep  = '1;
    egr_tdest  = 8'd3;
    egr_tdata  = 64'h6000;
    idle(1);
    egr_tdata  = 64'h6001;
    idle(1);
    egr_tvalid = 1'b0;
    sreset     = 1'b1;
    idle(1);
    chk("t6_rst_tready", 64'(egr_tready), 64'd0);
    idle(1);
    sreset = 1'b0;
    idle(1);
    chk("t6_tready", 64'(egr_tready), 64'd1);
    chk("t6_idle", 64'(port_tvalid), 64'd0);
    send_pkt(8'd3, 2, 64'h6100, 8'h0F);
    idle(12);
    chk("t6_count", 64'(on[3]), 64'd5);
    chk_pkt(3, 3, 2, 64'h6100, 8'h0F);
    chk("t6_p1_untouched", 64'(on[1]), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
